// File: rtl/step_pkg.sv
// Shared definitions for the head stepper drivers: FSM state encoding and
// direction constants.
package step_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DEB    = 3'd1,
    ST_CHECK  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STEP   = 3'd4,
    ST_SETTLE = 3'd5
  } step_state_t;

  localparam logic DIR_IN  = 1'b0;  // inward, position increases
  localparam logic DIR_OUT = 1'b1;  // outward, position decreases

endpackage

// File: rtl/step_phase_gen.sv
// Combinational phase-index to coil-pattern map for an N-phase unipolar motor.
// Even indices energise one coil; odd indices energise two adjacent coils.
module step_phase_gen #(
  parameter int unsigned NUM_COILS = 4,
  parameter int unsigned PH_W      = $clog2(2 * NUM_COILS)
) (
  input  logic [PH_W-1:0]      ph,
  output logic [NUM_COILS-1:0] coils
);

  logic [NUM_COILS-1:0] one_hot;
  logic [NUM_COILS-1:0] next_hot;

  always_comb begin
    one_hot  = NUM_COILS'(1) << ph[PH_W-1:1];
    next_hot = {one_hot[NUM_COILS-2:0], one_hot[NUM_COILS-1]};
    coils    = ph[0] ? (one_hot | next_hot) : one_hot;
  end

endmodule

// File: rtl/step_driver_multi.sv
// Floppy head stepper driver: debounced active-low STEP strobe, full/half step,
// position tracking with limit guards, settle interval and one pending step.
module step_driver_multi
  import step_pkg::*;
#(
  parameter int unsigned NUM_COILS     = 4,
  parameter int unsigned DEB_CYCLES    = 500,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned SETTLE_CYCLES = 2000,
  parameter int unsigned MAX_HALF      = 158,
  parameter int unsigned POS_W         = 8,
  parameter int unsigned IDLE_OFF      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  input  logic                 dir,
  input  logic                 en,
  input  logic                 half_mode,
  output logic [NUM_COILS-1:0] coils,
  output logic [POS_W-1:0]     pos,
  output logic                 tr0,
  output logic                 busy,
  output logic                 step_done,
  output logic                 blocked,
  output logic                 overrun
);

  localparam int unsigned NUM_PH = 2 * NUM_COILS;
  localparam int unsigned PH_W   = $clog2(NUM_PH);
  localparam int unsigned PH_W1  = PH_W + 1;
  localparam int unsigned POS_W1 = POS_W + 1;

  logic step_s1, step_r, step_r_d;
  logic dir_s1, dir_r;
  logic step_fall;

  step_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             done_d, blk_d, ovr_d;

  logic [PH_W-1:0]  delta;
  logic [PH_W:0]    ph_sum;
  logic [PH_W-1:0]  ph_fwd, ph_bwd;
  logic [POS_W:0]   pos_up;
  logic             refuse;
  logic [NUM_COILS-1:0] pattern;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_s1  <= 1'b1;
      step_r   <= 1'b1;
      step_r_d <= 1'b1;
      dir_s1   <= 1'b1;
      dir_r    <= 1'b1;
    end else begin
      step_s1  <= step;
      step_r   <= step_s1;
      step_r_d <= step_r;
      dir_s1   <= dir;
      dir_r    <= dir_s1;
    end
  end

  assign step_fall = step_r_d & ~step_r;

  // A full step from an odd phase moves by one to land on a single-coil phase.
  always_comb begin
    delta  = (mode_q || ph_q[0]) ? PH_W'(1) : PH_W'(2);
    ph_sum = {1'b0, ph_q} + {1'b0, delta};
    ph_fwd = (ph_sum >= PH_W1'(NUM_PH)) ? PH_W'(ph_sum - PH_W1'(NUM_PH)) : PH_W'(ph_sum);
    ph_bwd = (ph_q < delta) ? PH_W'({1'b0, ph_q} + PH_W1'(NUM_PH) - {1'b0, delta})
                            : (ph_q - delta);
    pos_up = {1'b0, pos_q} + POS_W1'(delta);
    refuse = (dir_q == DIR_OUT) ? (pos_q == '0) : (pos_up > POS_W1'(MAX_HALF));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    ph_d      = ph_q;
    pos_d     = pos_q;
    done_d    = 1'b0;
    blk_d     = 1'b0;
    ovr_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((en && !step_r) || pending_q) begin
          state_d   = ST_DEB;
          cnt_d     = CNT_W'(DEB_CYCLES - 1);
          mode_d    = half_mode;
          pending_d = 1'b0;
        end
      end
      ST_DEB: begin
        if (!en)              state_d = ST_IDLE;
        else if (cnt_q == '0) state_d = ST_CHECK;
        else                  cnt_d   = cnt_q - 1'b1;
      end
      ST_CHECK: begin
        state_d = step_r ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (!en) state_d = ST_IDLE;
        else if (step_r) begin
          state_d = ST_STEP;
          dir_d   = dir_r;
        end
      end
      ST_STEP: begin
        if (refuse) begin
          blk_d = 1'b1;
        end else begin
          done_d = 1'b1;
          if (dir_q == DIR_OUT) begin
            ph_d  = ph_bwd;
            pos_d = pos_q - POS_W'(delta);
          end else begin
            ph_d  = ph_fwd;
            pos_d = POS_W'(pos_up);
          end
        end
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
        // Settle always runs to completion; dropping en only discards the queued step.
        if (!en) pending_d = 1'b0;
        else if (step_fall) begin
          if (pending_q) ovr_d     = 1'b1;
          else           pending_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      mode_q    <= 1'b0;
      dir_q     <= DIR_IN;
      ph_q      <= '0;
      pos_q     <= '0;
      step_done <= 1'b0;
      blocked   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      ph_q      <= ph_d;
      pos_q     <= pos_d;
      step_done <= done_d;
      blocked   <= blk_d;
      overrun   <= ovr_d;
    end
  end

  step_phase_gen #(
    .NUM_COILS(NUM_COILS),
    .PH_W     (PH_W)
  ) u_phase (
    .ph   (ph_q),
    .coils(pattern)
  );

  assign coils = ((IDLE_OFF != 0) && !en) ? '0 : pattern;
  assign pos   = pos_q;
  assign tr0   = (pos_q == '0);
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_step_driver_multi.sv
// Directed bench for step_driver_multi: table of single steps plus hand-written
// latency, debounce, pending/overrun, limit, idle-off and async-reset sequences.
module tb_step_driver_multi;

  localparam int unsigned DEB    = 20;
  localparam int unsigned SETTLE = 40;

  logic       clk = 1'b0;
  logic       rst, step, dir, en, half_mode;
  logic [3:0] coils;
  logic [7:0] pos;
  logic       tr0, busy, step_done, blocked, overrun;

  int n_pass  = 0;
  int n_total = 0;
  int n_done  = 0;
  int n_blk   = 0;
  int n_ovr   = 0;

  typedef struct {
    logic       half;
    logic       d;
    logic [3:0] coils;
    logic [7:0] pos;
    logic       done;
    logic       blk;
  } vec_t;

  vec_t tbl [12];

  step_driver_multi #(
    .NUM_COILS    (4),
    .DEB_CYCLES   (DEB),
    .CNT_W        (16),
    .SETTLE_CYCLES(SETTLE),
    .MAX_HALF     (158),
    .POS_W        (8),
    .IDLE_OFF     (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .step     (step),
    .dir      (dir),
    .en       (en),
    .half_mode(half_mode),
    .coils    (coils),
    .pos      (pos),
    .tr0      (tr0),
    .busy     (busy),
    .step_done(step_done),
    .blocked  (blocked),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step_done === 1'b1) n_done++;
    if (blocked === 1'b1)   n_blk++;
    if (overrun === 1'b1)   n_ovr++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Full strobe; returns 1 time unit after the edge that commits the step.
  task automatic strobe(input logic h, input logic d, input int unsigned low_cyc);
    @(negedge clk);
    half_mode = h;
    dir       = d;
    step      = 1'b0;
    repeat (low_cyc) @(negedge clk);
    step = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  initial begin
    int d0, b0, o0;
    tbl[0]  = '{1'b0, 1'b1, 4'b0001, 8'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 4'b0001, 8'd0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 4'b0011, 8'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 4'b0010, 8'd2, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 4'b0110, 8'd3, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'b0100, 8'd4, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'b1000, 8'd6, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'b0001, 8'd8, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 4'b1001, 8'd7, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'b1000, 8'd6, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 4'b1100, 8'd5, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 4'b1000, 8'd6, 1'b1, 1'b0};

    rst = 1'b1; step = 1'b1; dir = 1'b0; en = 1'b1; half_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst coils", coils, 4'b0001);
    check("rst pos", pos, 8'd0);
    check("rst tr0", tr0, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst pulses", {step_done, blocked, overrun}, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    // First full inward step with exact 4-edge latency after the rise.
    @(negedge clk);
    step = 1'b0;
    repeat (30) @(negedge clk);
    step = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("lat edge3 coils", coils, 4'b0001);
    @(posedge clk);
    #1;
    check("lat edge4 coils", coils, 4'b0010);
    check("lat pos", pos, 8'd2);
    check("lat tr0", tr0, 1'b0);
    check("lat step_done", step_done, 1'b1);
    wait_idle("lat idle");
    check("lat done count", n_done, 1);

    for (int i = 0; i < 12; i++) begin
      strobe(tbl[i].half, tbl[i].d, 30);
      check($sformatf("v%0d coils", i), coils, tbl[i].coils);
      check($sformatf("v%0d pos", i), pos, tbl[i].pos);
      check($sformatf("v%0d tr0", i), tr0, (tbl[i].pos == 8'd0));
      check($sformatf("v%0d step_done", i), step_done, tbl[i].done);
      check($sformatf("v%0d blocked", i), blocked, tbl[i].blk);
      wait_idle($sformatf("v%0d idle", i));
    end

    // Strobe shorter than the debounce window is rejected as a bounce.
    d0 = n_done; b0 = n_blk;
    @(negedge clk);
    half_mode = 1'b0; dir = 1'b0; step = 1'b0;
    repeat (8) @(negedge clk);
    step = 1'b1;
    begin
      int unsigned n = 0;
      while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      check("short busy seen", busy, 1'b1);
    end
    wait_idle("short idle");
    check("short coils", coils, 4'b1000);
    check("short pos", pos, 8'd6);
    check("short pulses", (n_done - d0) + (n_blk - b0), 0);

    // Two strobes land inside one settle interval: one queued, one dropped.
    d0 = n_done; o0 = n_ovr;
    strobe(1'b0, 1'b0, 30);
    check("pend first pos", pos, 8'd8);
    repeat (4) @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
    step = 1'b1;
    repeat (4) @(negedge clk);
    step = 1'b0;
    repeat (70) @(negedge clk);
    step = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("pend second coils", coils, 4'b0010);
    check("pend second pos", pos, 8'd10);
    wait_idle("pend idle");
    repeat (SETTLE) @(negedge clk);
    check("pend no third", busy, 1'b0);
    check("pend steps", n_done - d0, 2);
    check("pend overrun", n_ovr - o0, 1);
    check("pend final pos", pos, 8'd10);

    // Walk inward to the last legal half-step.
    for (int i = 0; i < 74; i++) begin
      strobe(1'b0, 1'b0, 30);
      wait_idle("walk idle");
    end
    check("limit pos", pos, 8'd158);
    check("limit coils", coils, 4'b1000);
    strobe(1'b0, 1'b0, 30);
    check("limit blocked", blocked, 1'b1);
    check("limit no done", step_done, 1'b0);
    check("limit pos hold", pos, 8'd158);
    check("limit coils hold", coils, 4'b1000);
    wait_idle("limit idle");

    // Coils released while deselected; pattern returns on reselect.
    @(negedge clk);
    en = 1'b0;
    #1;
    check("off coils", coils, 4'b0000);
    check("off pos", pos, 8'd158);
    repeat (3) @(negedge clk);
    en = 1'b1;
    #1;
    check("on coils", coils, 4'b1000);

    // Asynchronous reset while a step waits for its rising edge.
    d0 = n_done;
    @(negedge clk);
    dir = 1'b1; step = 1'b0;
    repeat (30) @(negedge clk);
    check("ar busy before", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("ar coils", coils, 4'b0001);
    check("ar pos", pos, 8'd0);
    check("ar tr0", tr0, 1'b1);
    check("ar busy", busy, 1'b0);
    step = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("ar step lost", n_done - d0, 0);
    check("ar coils after", coils, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
